vedic_seq_divider: RTL and testbench
====================================

// Module: vedic_seq_divider
// PURPOSE
//  Iterative restoring divider; the inverse of the 4x4 Vedic multiplier path.
//  Takes an 8-bit product-width dividend and a 4-bit divisor.
//  Returns the 8-bit quotient and 4-bit remainder, one quotient bit per clock.
//  Sits downstream of the multiplier datapath. Used to recover factors and to
//  loop-back check multiplier results.
// PARAMETERS
//  DVD_W  8  dividend/quotient width; iteration count = DVD_W
//  DVS_W  4  divisor/remainder width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      dividend/divisor valid
//  in_ready   out  1      block can accept a request
//  dividend   in   DVD_W  numerator, unsigned
//  divisor    in   DVS_W  denominator, unsigned
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  quotient   out  DVD_W  floor(dividend/divisor)
//  remainder  out  DVS_W  dividend mod divisor
//  div_zero   out  1      result belongs to a divisor==0 request
// BEHAVIOUR
//  - Reset (rst_n=0, async):
//    - state=IDLE, counter=0, in_ready=1 once released
//    - out_valid=0, quotient=0, remainder=0, div_zero=0
//  - FSM states:
//    - IDLE -> CALC on in_valid&&in_ready with divisor!=0
//    - IDLE -> DONE on in_valid&&in_ready with divisor==0
//    - CALC -> DONE after DVD_W iterations
//    - DONE -> IDLE on out_valid&&out_ready
//  - in_ready=1 only in IDLE. There is no accept in the cycle DONE->IDLE: one
//    bubble cycle between results.
//  - Accept edge E0: operands are latched. The partial remainder register
//    (DVS_W+1 bits) is cleared, and the dividend is loaded into a shift
//    register that becomes the quotient.
//  - CALC step, at edges E1..E8:
//    - rem' = {rem[DVS_W-1:0], q_msb}
//    - t = rem' - {0,divisor} (DVS_W+1 bits)
//    - if t has no borrow: rem<=t and shift in 1; else rem<=rem' and shift in 0
//  - Normal latency: out_valid rises after edge E0+DVD_W (8 clocks), with
//    quotient/remainder final.
//  - Divide-by-zero: out_valid rises after E0 with quotient={DVD_W{1}},
//    remainder=0, div_zero=1. No iterations are run.
//  - div_zero=0 for every normal result.
//  - Outputs change only on entry to DONE. While out_valid=1 && out_ready=0,
//    all outputs hold stable.
//  - out_valid drops the cycle after the handshake. quotient/remainder keep
//    their last values; div_zero is held until the next result.
//  - Operand inputs are ignored outside the accept cycle; changing them
//    mid-CALC has no effect.
//  - rst_n asserted mid-CALC or mid-DONE aborts immediately to reset values;
//    the result is discarded.
//  - Invariant: dividend == quotient*divisor + remainder, and remainder <
//    divisor (divisor!=0).
// STRUCTURE
//  - Shared package vedic_pkg:
//    - localparam DVD_W/DVS_W defaults
//    - state typedef {IDLE, CALC, DONE} (2-bit encoding)
//    - ITER_CNT_W = $clog2(DVD_W+1)
//  - Sub-module div_step, combinational: one shift-subtract stage built from
//    the f_add NOR full-adder cell (subtract = add ~divisor with cin=1).
//    Outputs next rem and q bit. Top holds the FSM, counter and registers.
// TESTING
//  - 8'd200 / 4'd7 -> out_valid 8 clks after accept, quotient=28, remainder=4,
//    div_zero=0.
//  - 8'd255 / 4'd1 -> quotient=255, remainder=0.
//  - 8'd5 / 4'd15 -> quotient=0, remainder=5.
//  - 8'd77 / 4'd0 -> out_valid the next cycle, quotient=8'hFF, remainder=0,
//    div_zero=1.
//  - Backpressure and ordering:
//    - hold out_ready=0 for 5 clks after 8'd100/4'd9 -> outputs stable at 11 r1
//    - in_ready=0 throughout
//    - next request is accepted only after the handshake plus one bubble
//  - rst_n pulsed at iteration 4 of 8'd143/4'd11 -> all outputs 0, in_ready=1,
//    and a following 8'd143/4'd11 returns 13 r0.
//  - Exhaustive sweep of 256x16 operands with random out_ready: check the
//    invariant and a golden model on every result.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared definitions for the Vedic multiplier/divider datapath: default widths,
// the sequential divider state encoding and a counter-width helper.
package vedic_pkg;

  localparam int DVD_W_DEF = 8;
  localparam int DVS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int iter_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int ITER_CNT_W = iter_cnt_w(DVD_W_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract stage: shifts the next dividend bit into the
// partial remainder and subtracts the divisor via a NOR full-adder ripple chain.
module div_step #(
  parameter int DVS_W = 4
) (
  input  logic [DVS_W:0]   rem,
  input  logic             q_msb,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W:0]   rem_next,
  output logic             q_bit
);

  logic [DVS_W:0]   rem_sh;
  logic [DVS_W:0]   dvs_n;
  logic [DVS_W:0]   diff;
  logic [DVS_W+1:0] carry;

  // The partial remainder stays below the divisor, so its top bit is always 0
  // entering a step and the shift drops it.
  logic rem_msb_unused;
  assign rem_msb_unused = rem[DVS_W];

  assign rem_sh   = {rem[DVS_W-1:0], q_msb};
  assign dvs_n    = ~{1'b0, divisor};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= DVS_W; i++) begin : g_sub
    f_add u_fa (
      .a   (rem_sh[i]),
      .b   (dvs_n[i]),
      .cin (carry[i]),
      .sum (diff[i]),
      .cout(carry[i+1])
    );
  end

  // Carry out of rem_sh + ~divisor + 1 means no borrow: the divisor fits.
  assign q_bit    = carry[DVS_W+1];
  assign rem_next = q_bit ? diff : rem_sh;

endmodule

// File: rtl/f_add.sv
// Full-adder cell built only from 2-input NOR gates (nine-gate form).
module f_add (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, n4, n5, n6, n7;

  assign n1   = ~(a  | b);
  assign n2   = ~(a  | n1);
  assign n3   = ~(b  | n1);
  assign n4   = ~(n2 | n3);   // xnor(a, b)
  assign n5   = ~(n4 | cin);
  assign n6   = ~(n4 | n5);
  assign n7   = ~(cin | n5);
  assign sum  = ~(n6 | n7);
  assign cout = ~(n1 | n5);

endmodule

// File: rtl/vedic_seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with a
// valid/ready request side and a held-until-accepted result side.
module vedic_seq_divider #(
  parameter int DVD_W = vedic_pkg::DVD_W_DEF,
  parameter int DVS_W = vedic_pkg::DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_zero
);

  import vedic_pkg::*;

  localparam int CNT_W = iter_cnt_w(DVD_W);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] shreg;
  logic [DVS_W:0]   rem;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   rem_next;
  logic             q_bit;
  logic             accept;
  logic             last_iter;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CNT_W'(DVD_W - 1));

  div_step #(.DVS_W(DVS_W)) u_step (
    .rem     (rem),
    .q_msb   (shreg[DVD_W-1]),
    .divisor (dvs_q),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: non-blocking so every register samples pre-edge values.
    else        state <= state_nxt;
  end

  // Result registers load only on entry to DONE, so they hold under backpressure
  // and after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      shreg     <= '0;
      rem       <= '0;
      dvs_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            shreg <= dividend;
            dvs_q <= divisor;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt   <= cnt + 1'b1;
          shreg <= {shreg[DVD_W-2:0], q_bit};
          rem   <= rem_next;
          if (last_iter) begin
            quotient  <= {shreg[DVD_W-2:0], q_bit};
            remainder <= rem_next[DVS_W-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_seq_divider.sv
// Scoreboard bench for vedic_seq_divider: directed cases, backpressure,
// reset abort and a full operand sweep with random out_ready.
module tb_vedic_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       in_ready, out_valid, div_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  vedic_seq_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  function automatic exp_t golden(input logic [7:0] a, input logic [3:0] b);
    exp_t e;
    e.dvd = a;
    e.dvs = b;
    if (b == 4'd0) begin
      e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1;
    end else begin
      e.q = a / {4'd0, b}; e.r = 4'(a % {4'd0, b}); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] a, input logic [3:0] b, input exp_t e);
    int w = 0;
    in_valid = 1'b1; dividend = a; divisor = b;
    while (!in_ready && w < 40) begin @(negedge clk); w++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end else begin
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
  endtask

  // lat = number of edges after the accept edge before out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!out_valid) begin
      n_total++;
      $display("FAIL out_valid_timeout out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({out_valid, quotient, remainder, div_zero} !== 14'd0)
      $display("FAIL reset_outputs ov=%0b q=%0d r=%0d dz=%0b required all 0",
               out_valid, quotient, remainder, div_zero);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    exp_t v[3];
    exp_t e;
    int   lat;
    v[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
    v[1] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
    v[2] = '{8'd5,   4'd15, 8'd0,   4'd5, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send(v[i].dvd, v[i].dvs, v[i]);
      wait_valid(lat);
      e = sb.pop_front();
      n_total++;
      if (lat !== 8) $display("FAIL basic_latency[%0d] got %0d required 8", i, lat);
      else n_pass++;
      n_total++;
      if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
        $display("FAIL basic_result[%0d] q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                 i, quotient, remainder, div_zero, e.q, e.r, e.dz);
      else n_pass++;
      handshake();
      n_total++;
      if (out_valid !== 1'b0 || quotient !== e.q || remainder !== e.r)
        $display("FAIL basic_after_hs[%0d] ov=%0b q=%0d r=%0d required ov=0 q=%0d r=%0d",
                 i, out_valid, quotient, remainder, e.q, e.r);
      else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int   lat;
    send(8'd77, 4'd0, '{8'd77, 4'd0, 8'hFF, 4'd0, 1'b1});
    wait_valid(lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== 0) $display("FAIL dz_latency got %0d required 0", lat);
    else n_pass++;
    n_total++;
    if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
      $display("FAIL dz_result q=%0h r=%0d dz=%0b required q=%0h r=%0d dz=%0b",
               quotient, remainder, div_zero, e.q, e.r, e.dz);
    else n_pass++;
    handshake();
    n_total++;
    if (out_valid !== 1'b0 || div_zero !== 1'b1)
      $display("FAIL dz_held ov=%0b dz=%0b required ov=0 dz=1", out_valid, div_zero);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    send(8'd100, 4'd9, '{8'd100, 4'd9, 8'd11, 4'd1, 1'b0});
    wait_valid(lat);
    e = sb.pop_front();
    // Next request waits on in_valid through the whole stall.
    in_valid = 1'b1; dividend = 8'd60; divisor = 4'd6;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++;
      if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, e.q, e.r, e.dz})
        $display("FAIL stall[%0d] ov=%0b ir=%0b q=%0d r=%0d dz=%0b required ov=1 ir=0 q=%0d r=%0d dz=%0b",
                 c, out_valid, in_ready, quotient, remainder, div_zero, e.q, e.r, e.dz);
      else n_pass++;
    end
    handshake();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bubble ir=%0b ov=%0b required ir=1 ov=0", in_ready, out_valid);
    else n_pass++;
    @(posedge clk);
    sb.push_back('{8'd60, 4'd6, 8'd10, 4'd0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL b2b_accept in_ready=%0b required 0", in_ready);
    else n_pass++;
    wait_valid(lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== 8 || {quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
      $display("FAIL b2b_result lat=%0d q=%0d r=%0d dz=%0b required lat=8 q=%0d r=%0d dz=%0b",
               lat, quotient, remainder, div_zero, e.q, e.r, e.dz);
    else n_pass++;
    handshake();
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   lat;
    send(8'd143, 4'd11, golden(8'd143, 4'd11));
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({out_valid, quotient, remainder, div_zero} !== 14'd0)
      $display("FAIL abort_outputs ov=%0b q=%0d r=%0d dz=%0b required all 0",
               out_valid, quotient, remainder, div_zero);
    else n_pass++;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL abort_idle ir=%0b ov=%0b required ir=1 ov=0", in_ready, out_valid);
    else n_pass++;
    send(8'd143, 4'd11, '{8'd143, 4'd11, 8'd13, 4'd0, 1'b0});
    wait_valid(lat);
    e = sb.pop_front();
    n_total++;
    if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
      $display("FAIL abort_rerun q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
               quotient, remainder, div_zero, e.q, e.r, e.dz);
    else n_pass++;
    handshake();
  endtask

  task automatic test_sweep();
    exp_t e;
    logic done;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(8'(a), 4'(b), golden(8'(a), 4'(b)));
        done = 1'b0;
        for (int w = 0; w < 60 && !done; w++) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) done = 1'b1;
          else @(negedge clk);
        end
        if (!done) begin
          n_total++;
          $display("FAIL sweep_timeout a=%0d b=%0d out_valid=%0b required 1", a, b, out_valid);
          out_ready = 1'b0;
          sb.delete();
        end else begin
          e = sb.pop_front();
          n_total++;
          if ({quotient, remainder, div_zero} !== {e.q, e.r, e.dz})
            $display("FAIL sweep_golden %0d/%0d q=%0d r=%0d dz=%0b required q=%0d r=%0d dz=%0b",
                     e.dvd, e.dvs, quotient, remainder, div_zero, e.q, e.r, e.dz);
          else n_pass++;
          if (e.dvs != 4'd0) begin
            n_total++;
            if ((16'(quotient) * 16'(e.dvs) + 16'(remainder)) !== 16'(e.dvd) || remainder >= e.dvs)
              $display("FAIL sweep_invariant %0d/%0d q=%0d r=%0d required q*d+r=%0d and r<d",
                       e.dvd, e.dvs, quotient, remainder, e.dvd);
            else n_pass++;
          end
          @(posedge clk);
          @(negedge clk);
          out_ready = 1'b0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
